// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result stage behind the 8-bit adder.
// Captures sum/carry/overflow into a 2-entry FIFO, derives N/Z flags at
// capture time, and keeps sticky C/V status and a saturating overflow
// event counter for the ALU status register.
module alu_result_stage #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         sum,
    input  logic               carry,
    input  logic               overflow,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_result,
    output logic [3:0]         out_flags,
    output logic               sticky_c,
    output logic               sticky_v,
    output logic [COUNT_W-1:0] ovf_count,
    input  logic               clr_sticky
);

    // Entry 0 is always the head; entry 1 is only meaningful at occupancy 2.
    logic [1:0] occ;
    logic [7:0] res0, res1;
    logic [3:0] flg0, flg1;
    logic [3:0] in_flags;
    logic       push, pop;

    // Handshake decode and capture-time flags {N,Z,C,V}.
    assign in_flags  = {sum[7], (sum == 8'h00), carry, overflow};
    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Vacated entries are zeroed so an empty queue presents 0 with no stale data.
    assign out_result = res0;
    assign out_flags  = flg0;

    // Shift-register FIFO: pops move entry 1 into the head slot.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            // NOTE: the two entries are reset explicitly because the empty-queue
            // outputs are read straight from entry 0.
            occ  <= 2'd0;
            res0 <= 8'h00;
            flg0 <= 4'h0;
            res1 <= 8'h00;
            flg1 <= 4'h0;
        end else begin
            case (occ)
                2'd0: begin
                    if (push) begin
                        res0 <= sum;
                        flg0 <= in_flags;
                        occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        res0 <= sum;
                        flg0 <= in_flags;
                    end else if (push) begin
                        res1 <= sum;
                        flg1 <= in_flags;
                        occ  <= 2'd2;
                    end else if (pop) begin
                        res0 <= 8'h00;
                        flg0 <= 4'h0;
                        occ  <= 2'd0;
                    end
                end
                default: begin
                    // Full: no push is possible, only a pop.
                    if (pop) begin
                        res0 <= res1;
                        flg0 <= flg1;
                        res1 <= 8'h00;
                        flg1 <= 4'h0;
                        occ  <= 2'd1;
                    end
                end
            endcase
        end
    end

    // Sticky status: an accepted event beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_c <= 1'b0;
            sticky_v <= 1'b0;
        end else begin
            sticky_c <= (sticky_c && !clr_sticky) || (push && carry);
            sticky_v <= (sticky_v && !clr_sticky) || (push && overflow);
        end
    end

    // Saturating overflow counter; clear with a concurrent event restarts at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (push && overflow) begin
            if (clr_sticky) begin
                ovf_count <= COUNT_W'(1);
            end else if (!(&ovf_count)) begin
                ovf_count <= ovf_count + COUNT_W'(1);
            end
        end else if (clr_sticky) begin
            ovf_count <= '0;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage. Expected results are queued when
// a push is driven and compared against the head while it is presented.
// A second instance with COUNT_W=2 sees the same stimulus for counter saturation.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst, in_valid, carry, overflow, out_ready, clr_sticky;
    logic [7:0] sum;

    logic       in_ready, out_valid, sticky_c, sticky_v;
    logic [7:0] out_result;
    logic [3:0] out_flags;
    logic [7:0] ovf_count;

    logic       in_ready2, out_valid2, sticky_c2, sticky_v2;
    logic [7:0] out_result2;
    logic [3:0] out_flags2;
    logic [1:0] ovf_count2;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] sb[$];
    logic        m_sc, m_sv;
    int          m_cnt8, m_cnt2;

    always #5 clk = ~clk;

    alu_result_stage #(.COUNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .carry(carry),
        .overflow(overflow), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
        .sticky_c(sticky_c), .sticky_v(sticky_v), .ovf_count(ovf_count),
        .clr_sticky(clr_sticky)
    );

    alu_result_stage #(.COUNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .carry(carry),
        .overflow(overflow), .in_ready(in_ready2), .out_valid(out_valid2),
        .out_ready(out_ready), .out_result(out_result2), .out_flags(out_flags2),
        .sticky_c(sticky_c2), .sticky_v(sticky_v2), .ovf_count(ovf_count2),
        .clr_sticky(clr_sticky)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_flags(input logic [7:0] s, input logic c, input logic v);
        return {s[7], (s == 8'h00), c, v};
    endfunction

    task automatic model_reset();
        sb.delete();
        m_sc   = 1'b0;
        m_sv   = 1'b0;
        m_cnt8 = 0;
        m_cnt2 = 0;
    endtask

    // Apply one clock edge to the model using the inputs driven for this cycle.
    task automatic update_model();
        logic push_now, pop_now, ev_c, ev_v;
        if (rst) begin
            model_reset();
        end else begin
            push_now = in_valid && (sb.size() < 2);
            pop_now  = (sb.size() > 0) && out_ready;
            if (pop_now) void'(sb.pop_front());
            if (push_now) sb.push_back({sum, exp_flags(sum, carry, overflow)});
            ev_c = push_now && carry;
            ev_v = push_now && overflow;
            m_sc = ev_c ? 1'b1 : (clr_sticky ? 1'b0 : m_sc);
            m_sv = ev_v ? 1'b1 : (clr_sticky ? 1'b0 : m_sv);
            if (ev_v) begin
                m_cnt8 = clr_sticky ? 1 : ((m_cnt8 == 255) ? 255 : m_cnt8 + 1);
                m_cnt2 = clr_sticky ? 1 : ((m_cnt2 == 3) ? 3 : m_cnt2 + 1);
            end else if (clr_sticky) begin
                m_cnt8 = 0;
                m_cnt2 = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [11:0] head;
        head = (sb.size() > 0) ? sb[0] : 12'h000;
        check("in_ready",   in_ready,   sb.size() < 2);
        check("out_valid",  out_valid,  sb.size() > 0);
        check("out_result", out_result, head[11:4]);
        check("out_flags",  out_flags,  head[3:0]);
        check("sticky_c",   sticky_c,   m_sc);
        check("sticky_v",   sticky_v,   m_sv);
        check("ovf_count",  ovf_count,  m_cnt8);
        check("ovf_count_w2", ovf_count2, m_cnt2);
    endtask

    // One cycle: check outputs at the falling edge, then advance the model.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] s, input logic c, input logic o);
        in_valid = v;
        sum      = s;
        carry    = c;
        overflow = o;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        clr_sticky = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 8'h00);
        check("rst_out_flags", out_flags, 4'h0);

        // Single entry through an empty queue, consumer always ready.
        out_ready = 1'b1;
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("t1_valid", out_valid, 1'b1);
        check("t1_result", out_result, 8'h02);
        check("t1_flags", out_flags, 4'b0000);
        cycle();
        check("t1_empty_valid", out_valid, 1'b0);
        check("t1_empty_result", out_result, 8'h00);

        // Fill the queue with the consumer stalled.
        out_ready = 1'b0;
        drive(1'b1, 8'h00, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 8'h02, 1'b1, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("t2_full_in_ready", in_ready, 1'b0);
        check("t2_head_result", out_result, 8'h00);
        check("t2_head_flags", out_flags, 4'b0110);
        check("t2_sticky_c", sticky_c, 1'b1);
        check("t2_sticky_v", sticky_v, 1'b1);
        check("t2_ovf_count", ovf_count, 8'd1);
        // in_valid while full is ignored
        drive(1'b1, 8'h55, 1'b0, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check("t2_pop_result", out_result, 8'h02);
        check("t2_pop_flags", out_flags, 4'b0011);
        check("t2_pop_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        cycle();

        // Negative with overflow.
        out_ready = 1'b0;
        drive(1'b1, 8'h80, 1'b0, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("t3_flags", out_flags, 4'b1001);
        check("t3_ovf_count", ovf_count, 8'd2);
        out_ready = 1'b1;
        cycle();

        // Saturation of the 2-bit counter, then clear racing an overflow push.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b1);
            cycle();
        end
        check("t4_sat_w2", ovf_count2, 2'd3);
        check("t4_cnt_w8", ovf_count, 8'd7);
        clr_sticky = 1'b1;
        drive(1'b1, 8'h7f, 1'b0, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("t4_clr_race_w2", ovf_count2, 2'd1);
        check("t4_clr_race_w8", ovf_count, 8'd1);
        check("t4_clr_race_sv", sticky_v2, 1'b1);
        check("t4_clr_c", sticky_c, 1'b0);
        cycle();
        clr_sticky = 1'b0;
        check("t4_clr_v", sticky_v, 1'b0);
        check("t4_clr_cnt", ovf_count, 8'd0);
        cycle();

        // Push and pop together at occupancy 1.
        out_ready = 1'b0;
        drive(1'b1, 8'hA1, 1'b0, 1'b0);
        cycle();
        out_ready = 1'b1;
        drive(1'b1, 8'hB2, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("t5_in_ready", in_ready, 1'b1);
        check("t5_head", out_result, 8'hB2);
        check("t5_flags", out_flags, 4'b1010);
        cycle();

        // Back-to-back streaming of 8 entries.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle();
            check("t5_stream_ready", in_ready, 1'b1);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        check("t5_drained", out_valid, 1'b0);

        // Reset with two entries buffered and a concurrent push/pop.
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 1'b1, 1'b1);
        cycle();
        drive(1'b1, 8'h22, 1'b1, 1'b1);
        cycle();
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        cycle();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_in_ready", in_ready, 1'b1);
        check("t6_result", out_result, 8'h00);
        check("t6_sticky_c", sticky_c, 1'b0);
        check("t6_sticky_v", sticky_v, 1'b0);
        check("t6_ovf_count", ovf_count, 8'd0);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
